// File: rtl/alu_control_seq.sv
// ALU control decoder with an optional RV32M sequencer: a shift-add multiplier and a
// restoring divider share one set of registers and take XLEN steps per operation.
module alu_control_seq #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      AluOp,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [2:0]      AluC,
  output logic            mext,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic            neg_q_reg, neg_r_reg, divzero_reg;
  logic [XLEN-1:0] opd_reg, acc_reg, lo_reg;

  always_comb begin
    AluC = 3'b000;
    case (AluOp)
      2'b01: AluC = 3'b001;
      2'b10: begin
        if (func7 == 7'b0100000 && func3 == 3'b000) AluC = 3'b001;
        else begin
          case (func3)
            3'b111:  AluC = 3'b010;
            3'b110:  AluC = 3'b011;
            3'b100:  AluC = 3'b100;
            3'b010:  AluC = 3'b101;
            3'b011:  AluC = 3'b110;
            default: AluC = 3'b000;
          endcase
        end
      end
      default: AluC = 3'b000;
    endcase
  end

  assign mext = ENABLE_M && (AluOp == 2'b10) && (func7 == 7'b0000001);

  // Operand conditioning at launch: signed ops run on magnitudes.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
    b_signed = func3[2] ? ~func3[0] : (func3[1:0] == 2'b01);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  // MUL: {acc,lo} is the product, multiplier consumed from lo[0].
  // DIV: acc is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_next;

  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opd_reg} : '0);
    div_shift = {acc_reg, lo_reg[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opd_reg});
    div_diff  = div_shift[XLEN-1:0] - opd_reg;
    prod_s    = neg_q_reg ? -{acc_reg, lo_reg} : {acc_reg, lo_reg};
    if (!op_reg[2])
      res_next = (op_reg[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (!op_reg[1])
      res_next = divzero_reg ? '1 : (neg_q_reg ? -lo_reg : lo_reg);
    else
      res_next = neg_r_reg ? -acc_reg : acc_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      divzero_reg <= 1'b0;
      opd_reg     <= '0;
      acc_reg     <= '0;
      lo_reg      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && mext) begin
            op_reg      <= func3;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            divzero_reg <= (b == '0);
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy        <= 1'b1;
            if (func3[2]) begin
              opd_reg   <= b_mag;
              lo_reg    <= a_mag;
              state_reg <= DIV;
            end else begin
              opd_reg   <= a_mag;
              lo_reg    <= b_mag;
              state_reg <= MUL;
            end
          end
        end
        MUL: begin
          acc_reg <= mul_sum[XLEN:1];
          lo_reg  <= {mul_sum[0], lo_reg[XLEN-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(XLEN - 1)) state_reg <= DONE;
        end
        DIV: begin
          acc_reg <= div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_reg  <= {lo_reg[XLEN-2:0], div_ge};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(XLEN - 1)) state_reg <= DONE;
        end
        default: begin
          result    <= res_next;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode sweep, directed and random M ops
// against an arithmetic reference model, mid-op reset, and an ENABLE_M=0 build.
module tb_alu_control_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      AluOp;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic            start;
  logic [XLEN-1:0] a, b;

  logic [2:0]      aluc_m, aluc_n;
  logic            mext_m, busy_m, done_m, mext_n, busy_n, done_n;
  logic [XLEN-1:0] result_m, result_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .AluOp(AluOp), .func3(func3), .func7(func7), .start(start),
    .a(a), .b(b), .AluC(aluc_m), .mext(mext_m), .busy(busy_m), .done(done_m), .result(result_m)
  );

  alu_control_seq #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .AluOp(AluOp), .func3(func3), .func7(func7), .start(start),
    .a(a), .b(b), .AluC(aluc_n), .mext(mext_n), .busy(busy_n), .done(done_n), .result(result_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] aluc_ref(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    if (op == 2'b01) return 3'd1;
    if (op != 2'b10) return 3'd0;
    if (f7 == 7'h20 && f3 == 3'd0) return 3'd1;
    case (f3)
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Reference results from 64-bit products and native integer division.
  function automatic logic [31:0] mref(input logic [2:0] f3, input logic [31:0] x,
                                       input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    int ix, iy;
    logic ovf;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    ix = x;
    iy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(ix / iy));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : (ovf ? 32'd0 : 32'(ix % iy));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Launches from the current cycle and returns in the cycle where done is seen.
  // Operands are scrambled and start is re-pulsed while busy; neither may matter.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    int n;
    bit got;
    AluOp = 2'b10; func7 = 7'b0000001; func3 = f3; a = x; b = y; start = 1'b1;
    #1;
    chk({tag, " mext"}, 64'(mext_m), 64'd1);
    tick();
    start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (n == 0) begin
        chk({tag, " busy@1"}, 64'(busy_m), 64'd1);
        chk({tag, " done@1"}, 64'(done_m), 64'd0);
      end
      a = $urandom;
      b = $urandom;
      start = (n == 4 || n == 9);
      tick();
      n++;
      if (done_m) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " result"}, 64'(result_m), 64'(exp));
    chk({tag, " busy@done"}, 64'(busy_m), 64'd0);
    $display("op f3=%0d a=%h b=%h -> result=%h edges=%0d", f3, x, y, result_m, n);
  endtask

  initial begin
    int dcount;
    logic [6:0]  f7tab [3];
    logic [2:0]  rf3;
    logic [31:0] rx, ry;
    f7tab[0] = 7'h00; f7tab[1] = 7'h20; f7tab[2] = 7'h01;

    rst = 1'b1; start = 1'b0; AluOp = 2'b00; func3 = 3'd0; func7 = 7'd0; a = '0; b = '0;
    repeat (3) tick();
    chk("reset busy", 64'(busy_m), 64'd0);
    chk("reset done", 64'(done_m), 64'd0);
    chk("reset result", 64'(result_m), 64'd0);
    rst = 1'b0;
    tick();

    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int k = 0; k < 3; k++) begin
          AluOp = 2'(op); func3 = 3'(f3); func7 = f7tab[k];
          #1;
          chk("decode AluC", 64'(aluc_m), 64'(aluc_ref(AluOp, func3, func7)));
          chk("decode mext", 64'(mext_m), 64'((op == 2) && (k == 2)));
          chk("nom AluC", 64'(aluc_n), 64'(aluc_ref(AluOp, func3, func7)));
          chk("nom mext", 64'(mext_n), 64'd0);
        end
    $display("decode sweep done: %0d checks so far", checks);
    tick();

    // Directed ops run back-to-back: each relaunch is in the done cycle of the last.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH");
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, "DIV");
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, "REM");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "REMU");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIVU0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, "REM0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIVOVF");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "REMOVF");
    tick();
    chk("done pulse width", 64'(done_m), 64'd0);

    for (int i = 0; i < 30; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 255));
        default: ;
      endcase
      run_op(rf3, rx, ry, mref(rf3, rx, ry), "RAND");
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU pre-reset");
    tick();
    AluOp = 2'b10; func7 = 7'b0000001; func3 = 3'd4; a = 32'd1000; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset busy", 64'(busy_m), 64'd0);
    chk("midreset done", 64'(done_m), 64'd0);
    chk("midreset result", 64'(result_m), 64'd0);
    dcount = 0;
    repeat (40) begin
      tick();
      if (done_m) dcount++;
    end
    chk("midreset no done", 64'(dcount), 64'd0);
    $display("mid-op reset: busy=%0b result=%h stray done=%0d", busy_m, result_m, dcount);

    AluOp = 2'b10; func7 = 7'b0000001; func3 = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    #1;
    chk("nom mext", 64'(mext_n), 64'd0);
    tick();
    start = 1'b0;
    chk("nom busy", 64'(busy_n), 64'd0);
    dcount = 0;
    repeat (40) begin
      tick();
      if (done_n || busy_n) dcount++;
    end
    chk("nom inactive", 64'(dcount), 64'd0);
    chk("nom result", 64'(result_n), 64'd0);
    $display("ENABLE_M=0 start: busy=%0b result=%h activity=%0d", busy_n, result_n, dcount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
